alu_cmd_master: RTL and testbench

ALU_CMD_MASTER -- requirements
Module: alu_cmd_master

---
 rtl/alu_cmd_master.sv | 148 ++++++++++++++
 tb/tb_alu_cmd_master.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_master.sv
// alu_cmd_master: writes a command's operands and opcode to an AXI-Lite ALU slave,
// reads the result back and returns it on a valid/ready response port.
module alu_cmd_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 8,
   parameter int OP1_ADDR   = 0,
   parameter int OP2_ADDR   = 1,
   parameter int OPC_ADDR   = 2,
   parameter int RES_ADDR   = 3,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [DATA_WIDTH-1:0] cmd_op1,
   input  logic [DATA_WIDTH-1:0] cmd_op2,
   input  logic [DATA_WIDTH-1:0] cmd_opcode,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-1:0] awaddr,
   output logic                  awvalid,
   input  logic                  awready,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic                  wvalid,
   input  logic                  wready,
   input  logic [1:0]            bresp,
   input  logic                  bvalid,
   output logic                  bready,
   output logic [ADDR_WIDTH-1:0] araddr,
   output logic                  arvalid,
   input  logic                  arready,
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic [1:0]            rresp,
   input  logic                  rvalid,
   output logic                  rready
);
   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RESP} state_t;

   state_t                state, nxt;
   logic [DATA_WIDTH-1:0] op1, op2, opc, op1_d, op2_d, opc_d, rsp_data_d, wdata_d;
   logic [ADDR_WIDTH-1:0] awaddr_d;
   logic [1:0]            widx, widx_d;
   logic                  err, err_d;
   logic [TW-1:0]         tcnt, tcnt_d;
   logic                  aw_n, w_n, timed;

   assign rsp_err = err;

   always_comb begin
      aw_n       = awvalid & ~awready;
      w_n        = wvalid & ~wready;
      timed      = (state != IDLE) && (state != RESP);
      nxt        = state;
      op1_d      = op1;
      op2_d      = op2;
      opc_d      = opc;
      widx_d     = widx;
      err_d      = err;
      rsp_data_d = rsp_data;
      case (state)
         IDLE: if (cmd_valid && cmd_ready) begin
            nxt        = WADDR;
            op1_d      = cmd_op1;
            op2_d      = cmd_op2;
            opc_d      = cmd_opcode;
            widx_d     = 2'd0;
            err_d      = 1'b0;
            rsp_data_d = '0;
         end
         WADDR: if (!aw_n && !w_n) nxt = WRESP;
         WRESP: if (bvalid) begin
            if (bresp != 2'b00) begin
               err_d = 1'b1;
               nxt   = RESP;
            end else if (widx != 2'd2) begin
               widx_d = widx + 2'd1;
               nxt    = WADDR;
            end else nxt = RADDR;
         end
         RADDR: if (arready) nxt = RDATA;
         RDATA: if (rvalid) begin
            rsp_data_d = rdata;
            err_d      = err | (rresp != 2'b00);
            nxt        = RESP;
         end
         RESP: if (rsp_ready) nxt = IDLE;
         default: nxt = IDLE;
      endcase
      // a stalled handshake gives up once the wait budget is spent
      if (timed && nxt == state && tcnt == TW'(TIMEOUT - 1)) begin
         nxt        = RESP;
         err_d      = 1'b1;
         rsp_data_d = '0;
      end
      tcnt_d   = (nxt != state || !timed) ? '0 : tcnt + TW'(1);
      awaddr_d = widx_d == 2'd0 ? ADDR_WIDTH'(OP1_ADDR) :
                 widx_d == 2'd1 ? ADDR_WIDTH'(OP2_ADDR) : ADDR_WIDTH'(OPC_ADDR);
      wdata_d  = widx_d == 2'd0 ? op1_d : widx_d == 2'd1 ? op2_d : opc_d;
   end

   // all handshake outputs are registered from the next state, so no valid follows a ready combinationally
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         op1       <= '0;
         op2       <= '0;
         opc       <= '0;
         widx      <= 2'd0;
         err       <= 1'b0;
         tcnt      <= '0;
         rsp_data  <= '0;
         awaddr    <= '0;
         wdata     <= '0;
         araddr    <= '0;
         cmd_ready <= 1'b0;
         awvalid   <= 1'b0;
         wvalid    <= 1'b0;
         bready    <= 1'b0;
         arvalid   <= 1'b0;
         rready    <= 1'b0;
         rsp_valid <= 1'b0;
      end else begin
         state     <= nxt;
         op1       <= op1_d;
         op2       <= op2_d;
         opc       <= opc_d;
         widx      <= widx_d;
         err       <= err_d;
         tcnt      <= tcnt_d;
         rsp_data  <= rsp_data_d;
         awaddr    <= awaddr_d;
         wdata     <= wdata_d;
         araddr    <= ADDR_WIDTH'(RES_ADDR);
         cmd_ready <= nxt == IDLE;
         awvalid   <= nxt == WADDR && (state != WADDR || aw_n);
         wvalid    <= nxt == WADDR && (state != WADDR || w_n);
         bready    <= nxt == WRESP;
         arvalid   <= nxt == RADDR;
         rready    <= nxt == RDATA;
         rsp_valid <= nxt == RESP;
      end
   end
endmodule

// File: tb/tb_alu_cmd_master.sv
// tb_alu_cmd_master: scoreboard bench with a small AXI-Lite ALU slave model behind the master.
module tb_alu_cmd_master;
   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rstn;
   logic        cmd_valid, cmd_ready;
   logic [7:0]  cmd_op1, cmd_op2, cmd_opcode;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [7:0]  rsp_data;
   logic [31:0] awaddr, araddr;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic [7:0]  wdata, rdata;
   logic [1:0]  bresp, rresp;
   logic        arvalid, arready, rvalid, rready;

   alu_cmd_master #(.TIMEOUT(TO)) dut (
      .clk(clk), .rstn(rstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op1(cmd_op1), .cmd_op2(cmd_op2), .cmd_opcode(cmd_opcode),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [7:0] o);
      return o[1:0] == 2'd0 ? a + b : o[1:0] == 2'd1 ? a - b : o[1:0] == 2'd2 ? a & b : a ^ b;
   endfunction

   // slave knobs
   int          aw_delay = 0;
   int          w_delay  = 0;
   logic        ar_never = 1'b0;
   logic [31:0] berr_addr = 32'hFFFF_FFFF;

   int          aw_wait, w_wait;
   logic        aw_got, w_got;
   logic [31:0] aq;
   logic [7:0]  dq;
   logic [7:0]  mem [4];
   logic        aw_hs, w_hs;
   logic [31:0] a_now;
   logic [7:0]  d_now;

   assign awready = awvalid && aw_wait >= aw_delay;
   assign wready  = wvalid && w_wait >= w_delay;
   assign arready = arvalid && !ar_never;
   assign aw_hs   = awvalid && awready;
   assign w_hs    = wvalid && wready;
   assign a_now   = aw_got ? aq : awaddr;
   assign d_now   = w_got ? dq : wdata;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         aw_wait <= 0;
         w_wait  <= 0;
         aw_got  <= 1'b0;
         w_got   <= 1'b0;
         aq      <= '0;
         dq      <= '0;
         bvalid  <= 1'b0;
         bresp   <= 2'b00;
         rvalid  <= 1'b0;
         rdata   <= '0;
         rresp   <= 2'b00;
      end else begin
         aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
         w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
         if (bvalid && bready) bvalid <= 1'b0;
         if ((aw_got || aw_hs) && (w_got || w_hs) && !bvalid) begin
            bvalid          <= 1'b1;
            bresp           <= (a_now == berr_addr) ? 2'b01 : 2'b00;
            mem[a_now[1:0]] <= d_now;
            aw_got          <= 1'b0;
            w_got           <= 1'b0;
         end else begin
            if (aw_hs) begin
               aw_got <= 1'b1;
               aq     <= awaddr;
            end
            if (w_hs) begin
               w_got <= 1'b1;
               dq    <= wdata;
            end
         end
         if (rvalid && rready) rvalid <= 1'b0;
         if (arvalid && arready) begin
            rvalid <= 1'b1;
            rdata  <= alu_f(mem[0], mem[1], mem[2]);
            rresp  <= 2'b00;
         end
      end
   end

   // scoreboard
   logic [31:0] exp_aw [$];
   logic [7:0]  exp_w [$];
   logic [8:0]  exp_rsp [$];
   int          exp_aw_len = 1;
   int          exp_w_len  = 1;
   int          exp_ar_len = 1;
   int          ar_eps = 0;
   int          aw_cyc = 0, w_cyc = 0, ar_cyc = 0;
   logic        aw_prev_hs = 1'b0, w_prev_hs = 1'b0, ar_prev = 1'b0;

   // samples just before the edge, after the stimulus for that edge is settled
   always @(negedge clk) begin
      #2;
      if (aw_prev_hs) check("aw_drop", awvalid, 0);
      if (w_prev_hs) check("w_drop", wvalid, 0);
      aw_prev_hs = aw_hs;
      w_prev_hs  = w_hs;
      if (awvalid) begin
         if (exp_aw.size() == 0) check("aw_extra", awvalid, 0);
         else begin
            check("awaddr", awaddr, exp_aw[0]);
            if (awready) begin
               check("aw_len", aw_cyc + 1, exp_aw_len);
               void'(exp_aw.pop_front());
            end
         end
         aw_cyc = awready ? 0 : aw_cyc + 1;
      end else aw_cyc = 0;
      if (wvalid) begin
         if (exp_w.size() == 0) check("w_extra", wvalid, 0);
         else begin
            check("wdata", wdata, exp_w[0]);
            if (wready) begin
               check("w_len", w_cyc + 1, exp_w_len);
               void'(exp_w.pop_front());
            end
         end
         w_cyc = wready ? 0 : w_cyc + 1;
      end else w_cyc = 0;
      if (arvalid) begin
         check("araddr", araddr, 3);
         if (!ar_prev) ar_eps++;
         ar_cyc++;
      end else begin
         if (ar_prev) check("ar_len", ar_cyc, exp_ar_len);
         ar_cyc = 0;
      end
      ar_prev = arvalid;
      if (rsp_valid) begin
         if (exp_rsp.size() == 0) check("rsp_extra", rsp_valid, 0);
         else begin
            check("rsp", {rsp_err, rsp_data}, exp_rsp[0]);
            if (rsp_ready) void'(exp_rsp.pop_front());
         end
      end
   end

   task automatic step;
      @(negedge clk);
      #1;
   endtask

   task automatic start_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] o);
      logic [7:0] d [3];
      int nw;
      d[0] = a;
      d[1] = b;
      d[2] = o;
      nw = (berr_addr < 3) ? int'(berr_addr) + 1 : 3;
      for (int i = 0; i < nw; i++) begin
         exp_aw.push_back(32'(i));
         exp_w.push_back(d[i]);
      end
      exp_rsp.push_back((berr_addr < 3 || ar_never) ? 9'h100 : {1'b0, alu_f(a, b, o)});
      exp_aw_len = aw_delay + 1;
      exp_w_len  = w_delay + 1;
      exp_ar_len = ar_never ? TO : 1;
      ar_eps     = 0;
      check("acc_rdy", cmd_ready, 1);
      cmd_valid  = 1'b1;
      cmd_op1    = a;
      cmd_op2    = b;
      cmd_opcode = o;
      step;
      cmd_valid = 1'b0;
      check("acc_busy", cmd_ready, 0);
   endtask

   task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] o,
                          input int hold, input int exp_lat);
      int lat;
      start_cmd(a, b, o);
      lat = 1;
      while (!rsp_valid && lat < 200) begin
         check("busy_rdy", cmd_ready, 0);
         step;
         lat++;
      end
      check("rsp_seen", rsp_valid, 1);
      if (exp_lat > 0) check("latency", lat, exp_lat);
      for (int k = 0; k < hold; k++) begin
         check("hold_rdy", cmd_ready, 0);
         step;
      end
      rsp_ready = 1'b1;
      step;
      rsp_ready = 1'b0;
      check("rsp_done", rsp_valid, 0);
      check("rdy_back", cmd_ready, 1);
      check("reads", ar_eps, (berr_addr < 3) ? 0 : 1);
      check("sb_empty", exp_aw.size() + exp_w.size() + exp_rsp.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rstn       = 1'b0;
      cmd_valid  = 1'b0;
      cmd_op1    = '0;
      cmd_op2    = '0;
      cmd_opcode = '0;
      rsp_ready  = 1'b0;
      repeat (2) step;
      check("rst_ctl", {cmd_ready, rsp_valid, rsp_err, awvalid, wvalid, bready, arvalid, rready}, 0);
      check("rst_dat", {rsp_data, wdata}, 0);
      check("rst_addr", {awaddr, araddr}, 0);
      rstn = 1'b1;
      check("rdy_pre", cmd_ready, 0);
      step;
      check("rdy_post", cmd_ready, 1);

      run_cmd(8'h05, 8'h03, 8'h00, 0, 9);

      aw_delay = 3;
      run_cmd(8'h11, 8'h22, 8'h03, 0, 0);
      aw_delay = 0;

      berr_addr = 32'd1;
      run_cmd(8'h40, 8'h02, 8'h01, 0, 0);
      berr_addr = 32'hFFFF_FFFF;

      ar_never = 1'b1;
      run_cmd(8'h7F, 8'h01, 8'h00, 0, 0);
      ar_never = 1'b0;

      run_cmd(8'h20, 8'h05, 8'h01, 5, 9);
      run_cmd(8'hF0, 8'h3C, 8'h02, 0, 9);

      for (int i = 0; i < 6; i++) begin
         aw_delay = $urandom_range(0, 3);
         w_delay  = $urandom_range(0, 3);
         run_cmd(8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 2), 0);
      end
      aw_delay = 0;
      w_delay  = 0;

      start_cmd(8'h01, 8'h02, 8'h00);
      step;
      check("in_wresp", bready, 1);
      rstn = 1'b0;
      #1;
      check("arst_ctl", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready}, 0);
      exp_aw.delete();
      exp_w.delete();
      exp_rsp.delete();
      repeat (2) step;
      rstn = 1'b1;
      check("arst_pre", cmd_ready, 0);
      step;
      check("arst_post", cmd_ready, 1);
      run_cmd(8'h05, 8'h03, 8'h00, 0, 9);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
